// File: rtl/lisa_prog_loader_pkg.sv
// rtl/lisa_prog_loader_pkg.sv - loader state encodings, default magic and shared helpers
package lisa_prog_loader_pkg;

    typedef enum logic [2:0] {
        LISA_LDR_ST_IDLE    = 3'd0,
        LISA_LDR_ST_LEN_HI  = 3'd1,
        LISA_LDR_ST_LEN_LO  = 3'd2,
        LISA_LDR_ST_PAYLOAD = 3'd3,
        LISA_LDR_ST_CHECK   = 3'd4,
        LISA_LDR_ST_RUN     = 3'd5,
        LISA_LDR_ST_ERROR   = 3'd6
    } ldr_state_e;

    localparam logic [7:0] LISA_LDR_MAGIC     = 8'h4C;
    localparam int         LISA_LDR_MEM_BYTES = 512;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/lisa_prog_loader_if.sv
// rtl/lisa_prog_loader_if.sv - host byte channel between bridge and loader
interface lisa_prog_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/lisa_prog_loader_checksum.sv
// rtl/lisa_prog_loader_checksum.sv - lisa_ldr_checksum: 8-bit wrapping frame checksum accumulator
module lisa_ldr_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] add_data,
    output logic       zero
);
    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 8'h00;
        end else if (add_en) begin
            acc_d = acc_q + add_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Flag includes the byte being presented so CHK is judged on its accepting edge.
    assign zero = ((acc_q + add_data) == 8'h00);

endmodule

// File: rtl/lisa_prog_loader.sv
// rtl/lisa_prog_loader.sv - framed bytecode image loader and run monitor; optional CHK byte via LISA_LOADER_CHECKSUM_EN
module lisa_prog_loader
    import lisa_prog_loader_pkg::*;
#(
    parameter int         MEM_BYTES = LISA_LDR_MEM_BYTES,
    parameter logic [7:0] MAGIC     = LISA_LDR_MAGIC
) (
    input  logic                clk,
    input  logic                rst,
    lisa_prog_loader_if.slave   host,
    output logic                prog_we,
    output logic [15:0]         prog_addr,
    output logic [7:0]          prog_data,
    output logic                core_rst,
    input  logic                core_halted,
    input  logic                core_ret_valid,
    input  logic [31:0]         core_ret_value,
    output logic                load_done,
    output logic                load_error,
    output logic                result_valid,
    output logic [31:0]         result_value,
    output logic [31:0]         run_cycles
);
    ldr_state_e  state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic        prog_we_q, prog_we_d;
    logic [15:0] prog_addr_q, prog_addr_d;
    logic [7:0]  prog_data_q, prog_data_d;
    logic        core_rst_q, core_rst_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;
    logic        result_valid_q, result_valid_d;
    logic [31:0] result_value_q, result_value_d;
    logic [31:0] run_cycles_q, run_cycles_d;

    logic        acc;
    logic        is_magic;
    logic [15:0] len_in;
    logic        restart;
    logic        load_end;

`ifdef LISA_LOADER_CHECKSUM_EN
    logic cksum_clr;
    logic cksum_add;
    logic cksum_zero;

    lisa_ldr_checksum u_cksum (
        .clk      (clk),
        .rst      (rst),
        .clr      (cksum_clr),
        .add_en   (cksum_add),
        .add_data (host.s_data),
        .zero     (cksum_zero)
    );
`endif

    assign host.s_ready = 1'b1;
    assign acc          = host.s_valid;
    assign is_magic     = (host.s_data == MAGIC);
    assign len_in       = {len_hi_q, host.s_data};

    always_comb begin
        state_d        = state_q;
        len_hi_d       = len_hi_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        prog_we_d      = 1'b0;
        prog_addr_d    = prog_addr_q;
        prog_data_d    = prog_data_q;
        core_rst_d     = core_rst_q;
        load_done_d    = load_done_q;
        load_error_d   = load_error_q;
        result_valid_d = result_valid_q;
        result_value_d = result_value_q;
        run_cycles_d   = run_cycles_q;
        restart        = 1'b0;
        load_end       = 1'b0;
`ifdef LISA_LOADER_CHECKSUM_EN
        cksum_clr      = 1'b0;
        cksum_add      = 1'b0;
`endif

        case (state_q)
            LISA_LDR_ST_IDLE: begin
                restart = acc && is_magic;
            end
            LISA_LDR_ST_LEN_HI: begin
                if (acc) begin
                    len_hi_d = host.s_data;
                    state_d  = LISA_LDR_ST_LEN_LO;
`ifdef LISA_LOADER_CHECKSUM_EN
                    cksum_add = 1'b1;
`endif
                end
            end
            LISA_LDR_ST_LEN_LO: begin
                if (acc) begin
`ifdef LISA_LOADER_CHECKSUM_EN
                    cksum_add = 1'b1;
`endif
                    if (len_in > 16'(MEM_BYTES)) begin
                        state_d      = LISA_LDR_ST_ERROR;
                        load_error_d = 1'b1;
                    end else if (len_in == 16'd0) begin
                        load_end = 1'b1;
                    end else begin
                        state_d = LISA_LDR_ST_PAYLOAD;
                        len_d   = len_in;
                        cnt_d   = 16'd0;
                    end
                end
            end
            LISA_LDR_ST_PAYLOAD: begin
                if (acc) begin
                    prog_we_d   = 1'b1;
                    prog_addr_d = cnt_q;
                    prog_data_d = host.s_data;
                    cnt_d       = cnt_q + 16'd1;
                    load_end    = (cnt_q + 16'd1 == len_q);
`ifdef LISA_LOADER_CHECKSUM_EN
                    cksum_add = 1'b1;
`endif
                end
            end
`ifdef LISA_LOADER_CHECKSUM_EN
            LISA_LDR_ST_CHECK: begin
                if (acc) begin
                    if (cksum_zero) begin
                        state_d     = LISA_LDR_ST_RUN;
                        core_rst_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d      = LISA_LDR_ST_ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end
`endif
            LISA_LDR_ST_RUN: begin
                if (!core_halted) begin
                    run_cycles_d = sat_inc32(run_cycles_q);
                end
                if (core_ret_valid && !result_valid_q) begin
                    result_valid_d = 1'b1;
                    result_value_d = core_ret_value;
                end
                restart = acc && is_magic;
            end
            LISA_LDR_ST_ERROR: begin
                restart = acc && is_magic;
            end
            default: begin
                state_d = LISA_LDR_ST_IDLE;
            end
        endcase

        if (load_end) begin
`ifdef LISA_LOADER_CHECKSUM_EN
            state_d     = LISA_LDR_ST_CHECK;
`else
            state_d     = LISA_LDR_ST_RUN;
            core_rst_d  = 1'b0;
            load_done_d = 1'b1;
`endif
        end

        // A restart overrides whatever the run monitor computed this cycle.
        if (restart) begin
            state_d        = LISA_LDR_ST_LEN_HI;
            core_rst_d     = 1'b1;
            load_done_d    = 1'b0;
            load_error_d   = 1'b0;
            result_valid_d = 1'b0;
            run_cycles_d   = 32'd0;
`ifdef LISA_LOADER_CHECKSUM_EN
            cksum_clr      = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= LISA_LDR_ST_IDLE;
            len_hi_q       <= 8'h00;
            len_q          <= 16'd0;
            cnt_q          <= 16'd0;
            prog_we_q      <= 1'b0;
            prog_addr_q    <= 16'd0;
            prog_data_q    <= 8'h00;
            core_rst_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            result_valid_q <= 1'b0;
            result_value_q <= 32'd0;
            run_cycles_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            len_hi_q       <= len_hi_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            prog_we_q      <= prog_we_d;
            prog_addr_q    <= prog_addr_d;
            prog_data_q    <= prog_data_d;
            core_rst_q     <= core_rst_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            result_valid_q <= result_valid_d;
            result_value_q <= result_value_d;
            run_cycles_q   <= run_cycles_d;
        end
    end

    assign prog_we      = prog_we_q;
    assign prog_addr    = prog_addr_q;
    assign prog_data    = prog_data_q;
    assign core_rst     = core_rst_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign result_valid = result_valid_q;
    assign result_value = result_value_q;
    assign run_cycles   = run_cycles_q;

endmodule

// File: tb/tb_lisa_prog_loader.sv
// tb/tb_lisa_prog_loader.sv - randomized frame loader bench with queue-based image and run model
module tb_lisa_prog_loader;

`ifdef LISA_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we;
    logic [15:0] prog_addr;
    logic [7:0]  prog_data;
    logic        core_rst;
    logic        core_halted;
    logic        core_ret_valid;
    logic [31:0] core_ret_value;
    logic        load_done;
    logic        load_error;
    logic        result_valid;
    logic [31:0] result_value;
    logic [31:0] run_cycles;

    lisa_prog_loader_if host ();

    lisa_prog_loader dut (
        .clk            (clk),
        .rst            (rst),
        .host           (host),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .core_rst       (core_rst),
        .core_halted    (core_halted),
        .core_ret_valid (core_ret_valid),
        .core_ret_value (core_ret_value),
        .load_done      (load_done),
        .load_error     (load_error),
        .result_valid   (result_valid),
        .result_value   (result_value),
        .run_cycles     (run_cycles)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] wr_q[$];
    logic [7:0]  pl[$];
    logic        rst_before;

    always @(negedge clk) begin
        if (prog_we === 1'b1) wr_q.push_back({prog_addr, prog_data});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rst_before   = core_rst;
        host.s_valid = 1'b1;
        host.s_data  = b;
        @(posedge clk);
        #1;
        host.s_valid = 1'b0;
        host.s_data  = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_core_rst"}, core_rst, 1);
        check_eq({tag, "_s_ready"}, host.s_ready, 1);
        check_eq({tag, "_prog_we"}, prog_we, 0);
        check_eq({tag, "_prog_addr"}, prog_addr, 0);
        check_eq({tag, "_prog_data"}, prog_data, 0);
        check_eq({tag, "_load_done"}, load_done, 0);
        check_eq({tag, "_load_error"}, load_error, 0);
        check_eq({tag, "_result_valid"}, result_valid, 0);
        check_eq({tag, "_result_value"}, result_value, 0);
        check_eq({tag, "_run_cycles"}, run_cycles, 0);
    endtask

    task automatic fill_payload(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    // Sends strays, header, payload (from pl) and CHK when that build is active.
    task automatic send_frame(input logic [15:0] len, input bit bad_chk, input int strays, input bit gaps);
        logic [7:0] sum;
        logic [7:0] b;
        wr_q.delete();
        for (int i = 0; i < strays; i++) begin
            b = 8'($urandom);
            if (b == 8'h4C) b = 8'h4D;
            send_byte(b);
        end
        send_byte(8'h4C);
        check_eq("magic_core_rst", core_rst, 1);
        check_eq("magic_load_done", load_done, 0);
        check_eq("magic_load_error", load_error, 0);
        check_eq("magic_result_valid", result_valid, 0);
        check_eq("magic_run_cycles", run_cycles, 0);
        core_halted    = 1'b0;
        core_ret_valid = 1'b0;
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        sum = len[15:8] + len[7:0];
        if (len > 16'd512) return;
        for (int i = 0; i < int'(len); i++) begin
            if (gaps) idle($urandom_range(0, 2));
            send_byte(pl[i]);
            sum = sum + pl[i];
        end
        if (CK) begin
            if (gaps) idle($urandom_range(0, 2));
            b = 8'h00 - sum;
            if (bad_chk) b = b + 8'd1;
            send_byte(b);
        end
    endtask

    task automatic check_image(input string tag, input int len);
        int bad;
        bad = 0;
        check_eq({tag, "_wr_count"}, wr_q.size(), len);
        if (wr_q.size() == len) begin
            for (int i = 0; i < len; i++) begin
                if (wr_q[i] !== {16'(i), pl[i]}) bad++;
            end
        end
        check_eq({tag, "_wr_bad"}, bad, 0);
    endtask

    // Expected result: frame accepted unless oversize or (checksum build) corrupted CHK.
    task automatic check_outcome(input string tag, input int len, input bit bad_chk,
                                 input int n_run, input logic [31:0] v);
        bit ok;
        ok = (len <= 512) && !(CK && bad_chk);
        check_eq({tag, "_rst_before_last"}, rst_before, 1);
        if (!ok) begin
            check_eq({tag, "_err"}, load_error, 1);
            check_eq({tag, "_err_core_rst"}, core_rst, 1);
            check_eq({tag, "_err_done"}, load_done, 0);
            idle(3);
            check_image(tag, (len > 512) ? 0 : len);
            check_eq({tag, "_err_core_rst_hold"}, core_rst, 1);
            return;
        end
        check_eq({tag, "_core_rst"}, core_rst, 0);
        check_eq({tag, "_done"}, load_done, 1);
        check_eq({tag, "_error"}, load_error, 0);
        idle(n_run);
        core_halted    = 1'b1;
        core_ret_valid = 1'b1;
        core_ret_value = v;
        idle(1);
        check_eq({tag, "_res_valid"}, result_valid, 1);
        check_eq({tag, "_res_value"}, result_value, v);
        check_eq({tag, "_run_cycles"}, run_cycles, n_run);
        core_ret_value = ~v;
        idle($urandom_range(1, 5));
        check_eq({tag, "_res_hold"}, result_value, v);
        check_eq({tag, "_cycles_hold"}, run_cycles, n_run);
        core_ret_valid = 1'b0;
        check_image(tag, len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        int n_run;
        host.s_valid   = 1'b0;
        host.s_data    = 8'h00;
        core_halted    = 1'b0;
        core_ret_valid = 1'b0;
        core_ret_value = 32'd0;
        #12;
        check_reset_vals("reset");
        rst = 1'b0;
        idle(2);

        pl = '{8'hA1, 8'hB2, 8'hC3};
        send_frame(16'd3, 1'b0, 0, 1'b0);
        check_outcome("basic", 3, 1'b0, 7, 32'd42);

        if (CK) begin
            send_frame(16'd3, 1'b1, 0, 1'b0);
            check_outcome("badchk", 3, 1'b1, 1, 32'd0);
            fill_payload(5);
            send_frame(16'd5, 1'b0, 0, 1'b0);
            check_outcome("after_bad", 5, 1'b0, 4, 32'h1234_5678);
        end

        send_frame(16'd513, 1'b0, 0, 1'b0);
        check_outcome("oversize", 513, 1'b0, 0, 32'd0);

        pl.delete();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        fill_payload(9);
        send_frame(16'd9, 1'b0, 0, 1'b1);
        check_outcome("strays_gaps", 9, 1'b0, 12, 32'hDEAD_BEEF);

        pl.delete();
        send_frame(16'd0, 1'b0, 1, 1'b0);
        check_outcome("len0", 0, 1'b0, 3, 32'd7);

        fill_payload(512);
        send_frame(16'd512, 1'b0, 0, 1'b0);
        check_outcome("len512", 512, 1'b0, 2, 32'hCAFE_0001);

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 5) == 0) len = $urandom_range(513, 65535);
            else len = $urandom_range(0, 40);
            n_run = $urandom_range(1, 20);
            fill_payload((len > 512) ? 0 : len);
            send_frame(16'(len), 1'b0, $urandom_range(0, 3), 1'($urandom));
            check_outcome($sformatf("rand%0d", k), len, 1'b0, n_run, $urandom);
        end

        fill_payload(10);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'd10);
        for (int i = 0; i < 4; i++) send_byte(pl[i]);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        #10;
        rst = 1'b0;
        idle(2);
        fill_payload(6);
        send_frame(16'd6, 1'b0, 0, 1'b1);
        check_outcome("post_rst", 6, 1'b0, 5, 32'd99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
